video_mem_arbiter: RTL and testbench
====================================

# video_mem_arbiter

Time-slot arbiter for the 8 KiB single-port video RAM shared by the VGA scanout (ZX Spectrum pixel/attribute fetch) and the CPU bus. Each 4-clock pixel period is split into a fixed VGA read slot and a fixed CPU read/write slot. Scanout therefore never stalls, and the CPU gets a guaranteed, bounded-latency access. The block sits between the VGA generator's `video_addr`/`video_data` pair, the CPU memory handshake and the video BRAM.

## Interface
Parameters:
- `ADDR_W`, 13: video RAM address width (8 KiB).
- `DATA_W`, 8: data width.

Ports:
- `clk`  in  1: system clock, 100 MHz. One clock domain.
- `rst`  in  1: asynchronous, active-high reset.
- `phase`  out  2: free-running slot counter. The VGA generator's 25 MHz enable is derived from `phase==3`.
- `vga_addr`  in  ADDR_W: scanout fetch address from the VGA generator.
- `vga_data`  out  DATA_W: registered read data for scanout. Held for 4 cycles.
- `cpu_req`  in  1: CPU access request. Level signal, held until `cpu_ack`.
- `cpu_we`  in  1: 1 = write, 0 = read. Must be stable while `cpu_req` is high.
- `cpu_addr`  in  ADDR_W: CPU address. Must be stable while `cpu_req` is high.
- `cpu_wdata`  in  DATA_W: CPU write data. Must be stable while `cpu_req` is high.
- `cpu_rdata`  out  DATA_W: CPU read data. Valid in the `cpu_ack` cycle and held until the next CPU read completes.
- `cpu_ack`  out  1: one-cycle completion pulse.
- `mem_addr`  out  ADDR_W: BRAM address (registered).
- `mem_we`  out  1: BRAM write enable (registered).
- `mem_wdata`  out  DATA_W: BRAM write data (registered).
- `mem_rdata`  in  DATA_W: BRAM read data. Valid one cycle after the BRAM samples `mem_addr`.

## Operation
- `phase` counts 0→1→2→3→0 and never stops. Every cycle the phase determines the action taken at the rising edge that ends it:
  - ph0: `mem_addr<=vga_addr`, `mem_we<=0` (VGA read launch).
  - ph1, `cpu_req==1`: `mem_addr<=cpu_addr`, `mem_we<=cpu_we`, `mem_wdata<=cpu_wdata`, internal `cpu_busy<=1`.
  - ph1, `cpu_req==0`: `mem_we<=0`, `cpu_busy<=0`.
  - ph2: `vga_data<=mem_rdata`, `mem_we<=0`. The write pulse is therefore exactly one cycle, during ph2.
  - ph3, `cpu_busy==1`: `cpu_ack<=1`. If `cpu_we==0`, also `cpu_rdata<=mem_rdata`. Then `cpu_busy<=0`.
  - All other cycles: `cpu_ack<=0`.
- VGA always has its slot; there is no priority logic and no starvation of either side.
- At most one CPU access per 4-cycle period. A requester that keeps `cpu_req` high after `cpu_ack` starts a new access at the next ph1 (back-to-back throughput: 1 access per 4 cycles). A requester with no further access drops `cpu_req` in the `cpu_ack` cycle (ph0).
- `cpu_req` is sampled only at the end of ph1. A request arriving in ph2, ph3 or ph0 waits for the next ph1.
- Same address in the same period (CPU write vs. VGA read): VGA returns the old data, because its read is sampled at the end of ph1 and the write at the end of ph2. The new data is visible to VGA from the next period.
- Addresses are `ADDR_W` bits, with no wrap or translation. `cpu_addr` and `vga_addr` pass through unchanged.
- Reset, asynchronous and effective immediately:
  - `phase=0`, `mem_addr=0`, `mem_we=0`, `mem_wdata=0`, `vga_data=0`, `cpu_rdata=0`, `cpu_ack=0`, `cpu_busy=0`.
  - A CPU access in flight is aborted and no `cpu_ack` is issued for it. A write whose `mem_we` is not yet sampled by the BRAM is lost.
  - The requester re-issues after reset.

## Timing
- VGA path latency: `vga_addr` sampled at the end of ph0 → `vga_data` updated at the end of ph2. The data is stable for the following 4 cycles (ph3 through the next ph2).
- CPU latency, with `cpu_req` first high in cycle c:
  - Best case, c is ph1: `cpu_ack` high in cycle c+3 (ph0).
  - Worst case, c is ph2: `cpu_ack` high in cycle c+6.
- `cpu_ack` is high for exactly one cycle, and only ever in ph0.
- `mem_we` is high only during ph2.
- BRAM contract: `mem_*` are sampled on the rising edge, and `mem_rdata` is valid in the cycle after the sampling edge (1-cycle synchronous read).
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then idle CPU with `vga_addr=0x0123` and BRAM[0x0123]=0xA5: `phase` cycles 0..3, `vga_data=0xA5` after the first ph2 edge, `mem_we` never high, `cpu_ack` never high.
- CPU write with `cpu_req` raised in ph1, `cpu_addr=0x1ABC`, `cpu_wdata=0x5A`: `mem_we=1` and `mem_addr=0x1ABC` during ph2 only, `cpu_ack` pulses 3 cycles later, and a later CPU read of 0x1ABC returns `cpu_rdata=0x5A`.
- CPU read with `cpu_req` raised in ph2: `cpu_ack` exactly 6 cycles after the request, with `cpu_rdata` equal to the BRAM content.
- Four back-to-back CPU writes with `cpu_req` held high: acks 4 cycles apart, and scanout `vga_data` for a constant `vga_addr` is unaffected (no glitch across all periods).
- CPU writes 0xFF to the address VGA is currently reading (old value 0x00): `vga_data=0x00` in that period and 0xFF in the next.
- `rst` asserted during ph2 of a CPU write: `mem_we` drops immediately, all outputs return to 0, no `cpu_ack` appears, and `phase` restarts at 0 on release.

Source files
------------

// File: rtl/video_mem_arbiter.sv
// rtl/video_mem_arbiter.sv - Fixed time-slot arbiter sharing the video BRAM between scanout and CPU.
// Each 4-clock period: ph0 launches the VGA read, ph1 launches the CPU access, ph2/ph3 capture the data.
module video_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic [1:0]        phase,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    PH_VGA_LAUNCH = 2'd0,
    PH_CPU_LAUNCH = 2'd1,
    PH_VGA_DATA   = 2'd2,
    PH_CPU_DATA   = 2'd3
  } phase_t;

  phase_t ph;
  logic   cpu_busy;
  logic   busy_write;

  assign phase = ph;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph         <= PH_VGA_LAUNCH;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      vga_data   <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_busy   <= 1'b0;
      busy_write <= 1'b0;
    end else begin
      ph      <= phase_t'(ph + 2'd1);
      cpu_ack <= 1'b0;
      case (ph)
        PH_VGA_LAUNCH: begin
          mem_addr <= vga_addr;
          mem_we   <= 1'b0;
        end
        PH_CPU_LAUNCH: begin
          if (cpu_req) begin
            mem_addr   <= cpu_addr;
            mem_we     <= cpu_we;
            mem_wdata  <= cpu_wdata;
            cpu_busy   <= 1'b1;
            busy_write <= cpu_we;
          end else begin
            mem_we   <= 1'b0;
            cpu_busy <= 1'b0;
          end
        end
        PH_VGA_DATA: begin
          vga_data <= mem_rdata;
          mem_we   <= 1'b0;
        end
        PH_CPU_DATA: begin
          // Write direction is latched at launch so a write never disturbs the held read data.
          if (cpu_busy) begin
            cpu_ack <= 1'b1;
            if (!busy_write) cpu_rdata <= mem_rdata;
          end
          cpu_busy <= 1'b0;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_video_mem_arbiter.sv
// tb/tb_video_mem_arbiter.sv - Scoreboard bench for video_mem_arbiter with a 1-cycle BRAM model.
module tb_video_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  phase;
  logic [12:0] vga_addr;
  logic [7:0]  vga_data;
  logic        cpu_req, cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_ack;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic model_init;
  logic [7:0] bram [0:8191];
  logic [7:0] shadow [0:8191];
  logic [7:0] exp_q [$];
  logic [7:0] last_rd;

  video_mem_arbiter #(.ADDR_W(13), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .phase(phase),
    .vga_addr(vga_addr), .vga_data(vga_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Read-first synchronous BRAM
  always @(posedge clk) begin
    if (model_init) begin
      for (int i = 0; i < 8192; i++) bram[i] <= 8'h00;
      bram[13'h0123] <= 8'hA5;
    end else if (mem_we) begin
      bram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= bram[mem_addr];
  end

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != 2'(p) && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (phase != 2'(p)) begin
      errors++;
      $display("FAIL wait_phase: phase=%0d required %0d", phase, p);
    end
  endtask

  task automatic do_cpu(input logic we, input logic [12:0] addr, input logic [7:0] wdata,
                        input int start_ph, input int exp_lat);
    logic [7:0] exp;
    logic exp_we;
    int req_cyc;
    int n;
    wait_phase(start_ph);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    req_cyc = cyc;
    if (we) begin
      shadow[addr] = wdata;
      exp = last_rd;
    end else begin
      exp = shadow[addr];
      last_rd = exp;
    end
    exp_q.push_back(exp);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      exp_we = we && (phase == 2'd2);
      checks++;
      if (mem_we !== exp_we) begin
        errors++;
        $display("FAIL mem_we_slot: mem_we=%0b in phase %0d required %0b", mem_we, phase, exp_we);
      end
      if (exp_we) begin
        checks++;
        if (mem_addr !== addr) begin
          errors++;
          $display("FAIL mem_addr_write: got %0h required %0h", mem_addr, addr);
        end
      end
    end while (!cpu_ack && n < 12);
    checks++;
    if (!cpu_ack) begin
      errors++;
      $display("FAIL ack_timeout: cpu_ack=0 required 1 within 12 cycles (addr %0h)", addr);
      exp_q.delete();
    end else begin
      checks++;
      if (cyc - req_cyc != exp_lat) begin
        errors++;
        $display("FAIL ack_latency: got %0d cycles required %0d", cyc - req_cyc, exp_lat);
      end
      exp = exp_q.pop_front();
      checks++;
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL cpu_rdata: got %0h required %0h (addr %0h)", cpu_rdata, exp, addr);
      end
      checks++;
      if (phase !== 2'd0) begin
        errors++;
        $display("FAIL ack_phase: ack in phase %0d required 0", phase);
      end
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL ack_width: cpu_ack=%0b required 0 after pulse", cpu_ack);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({phase, mem_addr, mem_we, mem_wdata, vga_data, cpu_rdata, cpu_ack} !== 43'd0) begin
      errors++;
      $display("FAIL reset_outputs: phase=%0d mem_addr=%0h mem_we=%0b wdata=%0h vga=%0h rdata=%0h ack=%0b required all 0",
               phase, mem_addr, mem_we, mem_wdata, vga_data, cpu_rdata, cpu_ack);
    end
  endtask

  task automatic test_idle_scan();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (phase !== 2'(i % 4)) begin
        errors++;
        $display("FAIL idle_phase: cycle %0d phase=%0d required %0d", i, phase, i % 4);
      end
      checks++;
      if (mem_we !== 1'b0 || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL idle_quiet: cycle %0d mem_we=%0b cpu_ack=%0b required 0 0", i, mem_we, cpu_ack);
      end
      checks++;
      if (vga_data !== ((i >= 3) ? 8'hA5 : 8'h00)) begin
        errors++;
        $display("FAIL idle_vga_data: cycle %0d got %0h required %0h", i, vga_data, (i >= 3) ? 8'hA5 : 8'h00);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cpu_write_read();
    do_cpu(1'b1, 13'h1ABC, 8'h5A, 1, 3);
    do_cpu(1'b0, 13'h1ABC, 8'h00, 1, 3);
    do_cpu(1'b1, 13'h1FFF, 8'hC3, 3, 5);
    do_cpu(1'b0, 13'h1FFF, 8'h00, 0, 4);
  endtask

  task automatic test_cpu_read_late();
    do_cpu(1'b0, 13'h0123, 8'h00, 2, 6);
    do_cpu(1'b0, 13'h0000, 8'h00, 2, 6);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    int prev_cyc;
    int n;
    wait_phase(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0200; cpu_wdata = 8'h10;
    shadow[cpu_addr] = cpu_wdata;
    exp_q.push_back(last_rd);
    prev_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        checks++;
        if (vga_data !== shadow[13'h0123]) begin
          errors++;
          $display("FAIL b2b_vga_glitch: vga_data=%0h required %0h", vga_data, shadow[13'h0123]);
        end
      end while (!cpu_ack && n < 8);
      checks++;
      if (!cpu_ack || cyc - prev_cyc != ((k == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL b2b_ack_spacing: access %0d ack=%0b after %0d cycles required %0d",
                 k, cpu_ack, cyc - prev_cyc, (k == 0) ? 3 : 4);
      end
      prev_cyc = cyc;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checks++;
      if (cpu_rdata !== exp) begin
        errors++;
        $display("FAIL b2b_rdata_hold: got %0h required %0h", cpu_rdata, exp);
      end
      if (k < 3) begin
        cpu_addr = 13'h0200 + 13'(k + 1);
        cpu_wdata = 8'h10 + 8'(k + 1);
        shadow[cpu_addr] = cpu_wdata;
        exp_q.push_back(last_rd);
      end else begin
        cpu_req = 1'b0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) do_cpu(1'b0, 13'h0200 + 13'(k), 8'h00, 1, 3);
  endtask

  task automatic test_same_address();
    logic [7:0] exp;
    vga_addr = 13'h0456;
    repeat (4) @(negedge clk);
    wait_phase(3);
    checks++;
    if (vga_data !== 8'h00) begin
      errors++;
      $display("FAIL same_addr_pre: vga_data=%0h required 00", vga_data);
    end
    wait_phase(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0456; cpu_wdata = 8'hFF;
    shadow[13'h0456] = 8'hFF;
    exp_q.push_back(last_rd);
    repeat (2) @(negedge clk);
    checks++;
    if (vga_data !== 8'h00) begin
      errors++;
      $display("FAIL same_addr_old: vga_data=%0h required 00", vga_data);
    end
    @(negedge clk);
    exp = exp_q.pop_front();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== exp) begin
      errors++;
      $display("FAIL same_addr_ack: ack=%0b rdata=%0h required 1 %0h", cpu_ack, cpu_rdata, exp);
    end
    cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (vga_data !== 8'hFF) begin
      errors++;
      $display("FAIL same_addr_new: vga_data=%0h required ff", vga_data);
    end
    vga_addr = 13'h0123;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    wait_phase(1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0777; cpu_wdata = 8'h33;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || phase !== 2'd2) begin
      errors++;
      $display("FAIL rst_pre_write: mem_we=%0b phase=%0d required 1 2", mem_we, phase);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({phase, mem_addr, mem_we, mem_wdata, vga_data, cpu_rdata, cpu_ack} !== 43'd0) begin
      errors++;
      $display("FAIL rst_async_clear: phase=%0d mem_addr=%0h mem_we=%0b wdata=%0h vga=%0h rdata=%0h ack=%0b required all 0",
               phase, mem_addr, mem_we, mem_wdata, vga_data, cpu_rdata, cpu_ack);
    end
    repeat (2) @(negedge clk);
    cpu_req = 1'b0;
    rst = 1'b0;
    last_rd = 8'h00;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (phase !== 2'(i % 4) || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL rst_restart: cycle %0d phase=%0d ack=%0b required %0d 0", i, phase, cpu_ack, i % 4);
      end
      @(negedge clk);
    end
    do_cpu(1'b0, 13'h0777, 8'h00, 1, 3);
  endtask

  initial begin
    rst = 1'b1; model_init = 1'b1;
    vga_addr = 13'h0123;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    last_rd = 8'h00;
    for (int i = 0; i < 8192; i++) shadow[i] = 8'h00;
    shadow[13'h0123] = 8'hA5;
    @(negedge clk);
    model_init = 1'b0;
    test_reset();
    test_idle_scan();
    test_cpu_write_read();
    test_cpu_read_late();
    test_back_to_back();
    test_same_address();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
